// File: rtl/timebase_capture_ctrl.sv
// Oscilloscope timebase divider and capture sequencer.
// Produces SAMPLE_EN strobes at BASE_DIV << STEP and writes one capture of NUM_SAMPLES into the sample buffer.
module timebase_capture_ctrl #(
    parameter int unsigned BASE_DIV    = 100,
    parameter int unsigned NUM_SAMPLES = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              CLK_IN,
    input  logic              RESET,
    input  logic              STEP_UP,
    input  logic              STEP_DOWN,
    input  logic              ARM,
    input  logic              TRIG,
    input  logic              AUTO,
    output logic              SAMPLE_EN,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic              CAPTURE_DONE,
    output logic              BUSY,
    output logic [2:0]        STEP,
    output logic [27:0]       PERIOD
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    localparam logic [27:0]       BASE = 28'(BASE_DIV);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);

    state_t            r_state;
    logic [2:0]        r_pend;
    logic [2:0]        r_step;
    logic [27:0]       r_cnt;
    logic [27:0]       r_period;
    logic              r_sample_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;

    logic [2:0]        w_sel;
    logic [27:0]       w_new_period;
    logic              w_wr;

    // Capture spacing is frozen: the applied step is reused while capturing.
    assign w_sel        = (r_state == S_CAPTURE) ? r_step : r_pend;
    assign w_new_period = BASE << w_sel;
    assign w_wr         = r_sample_en && (r_state == S_CAPTURE);

    always_ff @(posedge CLK_IN) begin
        if (!RESET) begin
            r_pend <= '0;
        end else if (STEP_UP && !STEP_DOWN && (r_pend != 3'd7)) begin
            r_pend <= r_pend + 3'd1;
        end else if (STEP_DOWN && !STEP_UP && (r_pend != 3'd0)) begin
            r_pend <= r_pend - 3'd1;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET) begin
            r_cnt       <= BASE - 28'd1;
            r_step      <= '0;
            r_period    <= BASE;
            r_sample_en <= 1'b0;
        end else if (r_cnt == '0) begin
            r_sample_en <= 1'b1;
            r_cnt       <= w_new_period - 28'd1;
            r_step      <= w_sel;
            r_period    <= w_new_period;
        end else begin
            r_sample_en <= 1'b0;
            r_cnt       <= r_cnt - 28'd1;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ARM) begin
                        r_state <= S_ARMED;
                        r_done  <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (TRIG) begin
                        r_state <= S_CAPTURE;
                        r_addr  <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_wr) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_addr == LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (AUTO || ARM) begin
                        r_state <= S_ARMED;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SAMPLE_EN    = r_sample_en;
    assign WR_EN        = w_wr;
    assign WR_ADDR      = r_addr;
    assign CAPTURE_DONE = r_done;
    assign BUSY         = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign STEP         = r_step;
    assign PERIOD       = r_period;

endmodule

// File: tb/tb_timebase_capture_ctrl.sv
// Bench for timebase_capture_ctrl with BASE_DIV=4, NUM_SAMPLES=8, ADDR_W=3.
// Expected write addresses are queued at trigger time and popped as writes appear.
module tb_timebase_capture_ctrl;

    localparam int unsigned BD = 4;
    localparam int unsigned NS = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          RESET = 1'b0;
    logic          STEP_UP = 1'b0, STEP_DOWN = 1'b0, ARM = 1'b0, TRIG = 1'b0, AUTO = 1'b0;
    logic          SAMPLE_EN, WR_EN, CAPTURE_DONE, BUSY;
    logic [AW-1:0] WR_ADDR;
    logic [2:0]    STEP;
    logic [27:0]   PERIOD;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0;
    int exp_q[$];

    timebase_capture_ctrl #(.BASE_DIV(BD), .NUM_SAMPLES(NS), .ADDR_W(AW)) dut (
        .CLK_IN(clk), .RESET(RESET), .STEP_UP(STEP_UP), .STEP_DOWN(STEP_DOWN),
        .ARM(ARM), .TRIG(TRIG), .AUTO(AUTO), .SAMPLE_EN(SAMPLE_EN), .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR), .CAPTURE_DONE(CAPTURE_DONE), .BUSY(BUSY), .STEP(STEP),
        .PERIOD(PERIOD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every buffer write must match the next queued address; a write with nothing queued is an error.
    always @(negedge clk) begin
        if (WR_EN) begin
            if (exp_q.size() == 0) chk("extra_wr", WR_EN, 1'b0);
            else                   chk("wr_addr", WR_ADDR, exp_q.pop_front());
        end
    end

    task automatic push_capture();
        for (int i = 0; i < NS; i++) exp_q.push_back(i);
    endtask

    task automatic wait_se(input string tag, input int exp, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!SAMPLE_EN && n < limit);
        if (!SAMPLE_EN)   chk({tag, "_timeout"}, SAMPLE_EN, 1'b1);
        else if (exp > 0) chk(tag, n, exp);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!CAPTURE_DONE && n < limit);
        if (!CAPTURE_DONE) chk({tag, "_timeout"}, CAPTURE_DONE, 1'b1);
    endtask

    task automatic pulse(input logic up, input logic dn);
        STEP_UP = up;
        STEP_DOWN = dn;
        @(negedge clk);
        STEP_UP = 1'b0;
        STEP_DOWN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and free-running divider.
        repeat (3) @(negedge clk);
        chk("rst_step", STEP, 0);
        chk("rst_period", PERIOD, BD);
        chk("rst_se", SAMPLE_EN, 0);
        chk("rst_wren", WR_EN, 0);
        chk("rst_addr", WR_ADDR, 0);
        chk("rst_done", CAPTURE_DONE, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b1;
        wait_se("se_first", 4, 20);
        wait_se("se_second", 4, 20);
        wait_se("se_third", 4, 20);

        // Step requests, saturation, simultaneous up/down.
        repeat (4) pulse(1'b1, 1'b0);
        wait_se("up4_reload", -1, 200);
        chk("up4_step", STEP, 4);
        chk("up4_period", PERIOD, 64);
        wait_se("up4_gap", 64, 200);
        repeat (8) pulse(1'b1, 1'b0);
        wait_se("up7_reload", -1, 200);
        chk("up7_step", STEP, 7);
        chk("up7_period", PERIOD, 512);
        wait_se("up7_gap", 512, 1100);
        repeat (5) pulse(1'b0, 1'b1);
        wait_se("dn2_reload", -1, 1100);
        chk("dn2_step", STEP, 2);
        chk("dn2_period", PERIOD, 16);
        pulse(1'b1, 1'b1);
        wait_se("both_reload", -1, 100);
        wait_se("both_gap", 16, 100);
        chk("both_step", STEP, 2);

        // Arm, trigger coincident with a strobe, step request mid-capture.
        ARM = 1'b1;
        @(negedge clk);
        ARM = 1'b0;
        chk("armed_busy", BUSY, 1);
        chk("armed_done", CAPTURE_DONE, 0);
        wait_se("arm_gap", 15, 100);
        chk("trig_nowr", WR_EN, 0);
        TRIG = 1'b1;
        push_capture();
        t0 = cyc;
        @(negedge clk);
        TRIG = 1'b0;
        STEP_DOWN = 1'b1;
        chk("cap_busy", BUSY, 1);
        @(negedge clk);
        STEP_DOWN = 1'b0;
        wait_done("cap1", 400);
        chk("cap1_time", cyc - t0, 8 * 16 + 1);
        chk("cap1_busy", BUSY, 0);
        chk("cap1_period", PERIOD, 16);
        chk("cap1_qempty", exp_q.size(), 0);
        wait_se("post_reload", -1, 100);
        chk("post_step", STEP, 1);
        chk("post_period", PERIOD, 8);
        wait_se("post_gap", 8, 100);
        chk("hold_done", CAPTURE_DONE, 1);
        chk("hold_busy", BUSY, 0);

        // Auto re-arm.
        AUTO = 1'b1;
        @(negedge clk);
        chk("auto_done_clr", CAPTURE_DONE, 0);
        chk("auto_busy", BUSY, 1);
        TRIG = 1'b1;
        push_capture();
        @(negedge clk);
        TRIG = 1'b0;
        wait_done("cap2", 300);
        chk("cap2_qempty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_1cyc", CAPTURE_DONE, 0);
        chk("rearm_busy", BUSY, 1);
        TRIG = 1'b1;
        push_capture();
        @(negedge clk);
        TRIG = 1'b0;

        // Reset mid-capture after the address-3 write.
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(WR_EN && WR_ADDR == 3'd3) && n < 200);
            if (!(WR_EN && WR_ADDR == 3'd3)) chk("addr3_timeout", WR_EN, 1'b1);
        end
        RESET = 1'b0;
        AUTO = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("mid_wren", WR_EN, 0);
        chk("mid_addr", WR_ADDR, 0);
        chk("mid_busy", BUSY, 0);
        chk("mid_step", STEP, 0);
        chk("mid_period", PERIOD, BD);
        chk("mid_done", CAPTURE_DONE, 0);
        RESET = 1'b1;
        wait_se("rel_first", 4, 20);
        wait_se("rel_second", 4, 20);

        // Trigger in IDLE is ignored.
        TRIG = 1'b1;
        @(negedge clk);
        TRIG = 1'b0;
        chk("idle_trig_busy", BUSY, 0);
        repeat (12) @(negedge clk);
        chk("idle_trig_busy2", BUSY, 0);
        chk("idle_trig_done", CAPTURE_DONE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
